// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, control enums, the control bundle and
// the defined bundle used for every illegal instruction.
package decode_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [4:0] {
      ALU_ADD    = 5'b00000,
      ALU_SUB    = 5'b00001,
      ALU_AND    = 5'b00010,
      ALU_OR     = 5'b00011,
      ALU_SLT    = 5'b00101,
      ALU_SLL    = 5'b00110,
      ALU_SRL    = 5'b00111,
      ALU_XOR    = 5'b01000,
      ALU_SLTU   = 5'b01001,
      ALU_SRA    = 5'b01010,
      ALU_PASSB  = 5'b01011,
      ALU_PCADD  = 5'b01100,
      ALU_MUL    = 5'b10000,
      ALU_MULH   = 5'b10001,
      ALU_MULHSU = 5'b10010,
      ALU_MULHU  = 5'b10011,
      ALU_DIV    = 5'b10100,
      ALU_DIVU   = 5'b10101,
      ALU_REM    = 5'b10110,
      ALU_REMU   = 5'b10111
   } alu_ctrl_e;

   typedef enum logic [2:0] {
      IMM_R = 3'b000,
      IMM_I = 3'b001,
      IMM_S = 3'b010,
      IMM_B = 3'b011,
      IMM_U = 3'b100,
      IMM_J = 3'b101
   } imm_src_e;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } result_src_e;

   typedef struct packed {
      logic        reg_write;
      logic        mem_write;
      logic        jump;
      logic        branch;
      logic        alu_src;
      logic        alu_src_a;
      logic        sum_src;
      result_src_e result_src;
      imm_src_e    imm_src;
      alu_ctrl_e   alu_ctrl;
      logic [1:0]  store_src;
      logic [2:0]  load_src;
      logic [2:0]  branch_type;
      logic        illegal;
   } ctrl_bundle_t;

   localparam int BUNDLE_W = $bits(ctrl_bundle_t);

   // Everything zero except the illegal flag, so nothing downstream can write state.
   localparam ctrl_bundle_t ILLEGAL_BUNDLE = ctrl_bundle_t'({{(BUNDLE_W-1){1'b0}}, 1'b1});

   // Base-ISA ALU op selected by funct3; alt picks SUB/SRA.
   function automatic alu_ctrl_e alu_from_f3(input logic [2:0] f3, input logic alt);
      alu_ctrl_e op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/instr_decode_comb.sv
// Combinational RV32I instruction decoder producing a ctrl_bundle_t.
// Define DECODE_M_EXT_EN to accept the M-extension R-type encodings.
module instr_decode_comb
   import decode_pkg::*;
(
   input  logic [31:0]  instr_i,
   output ctrl_bundle_t ctrl_o
);

   logic [6:0]   opcode;
   logic [2:0]   funct3;
   logic [6:0]   funct7;
   logic         legal;
   ctrl_bundle_t dec;
   logic         unused_fields;

   assign opcode        = instr_i[6:0];
   assign funct3        = instr_i[14:12];
   assign funct7        = instr_i[31:25];
   assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

   always_comb begin
      dec   = '0;
      legal = 1'b0;
      case (opcode)
         OP_R: begin
            dec.reg_write = 1'b1;
            dec.imm_src   = IMM_R;
            if (funct7 == F7_BASE) begin
               legal        = 1'b1;
               dec.alu_ctrl = alu_from_f3(funct3, 1'b0);
            end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
               legal        = 1'b1;
               dec.alu_ctrl = alu_from_f3(funct3, 1'b1);
            end
`ifdef DECODE_M_EXT_EN
            else if (funct7 == F7_MULDIV) begin
               legal        = 1'b1;
               dec.alu_ctrl = alu_ctrl_e'({2'b10, funct3});
            end
`else
            else begin
               legal = 1'b0;
            end
`endif
         end
         OP_IMM: begin
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.imm_src   = IMM_I;
            dec.alu_ctrl  = alu_from_f3(funct3, funct3 == 3'b101 && funct7 == F7_ALT);
            // Shift-immediates reuse funct7 as an opcode extension.
            case (funct3)
               3'b001:  legal = (funct7 == F7_BASE);
               3'b101:  legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
               default: legal = 1'b1;
            endcase
         end
         OP_LOAD: begin
            dec.reg_write  = 1'b1;
            dec.alu_src    = 1'b1;
            dec.imm_src    = IMM_I;
            dec.result_src = RES_MEM;
            dec.alu_ctrl   = ALU_ADD;
            dec.load_src   = funct3;
            legal = !(funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
         end
         OP_STORE: begin
            dec.mem_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.imm_src   = IMM_S;
            dec.alu_ctrl  = ALU_ADD;
            case (funct3)
               3'b000:  dec.store_src = 2'b10;
               3'b001:  dec.store_src = 2'b01;
               default: dec.store_src = 2'b00;
            endcase
            legal = (funct3 < 3'b011);
         end
         OP_BRANCH: begin
            dec.branch      = 1'b1;
            dec.imm_src     = IMM_B;
            dec.branch_type = funct3;
            case (funct3[2:1])
               2'b00:   dec.alu_ctrl = ALU_SUB;
               2'b10:   dec.alu_ctrl = ALU_SLT;
               default: dec.alu_ctrl = ALU_SLTU;
            endcase
            legal = (funct3[2:1] != 2'b01);
         end
         OP_LUI: begin
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.imm_src   = IMM_U;
            dec.alu_ctrl  = ALU_PASSB;
            legal         = 1'b1;
         end
         OP_AUIPC: begin
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.alu_src_a = 1'b1;
            dec.imm_src   = IMM_U;
            dec.alu_ctrl  = ALU_PCADD;
            legal         = 1'b1;
         end
         OP_JAL: begin
            dec.reg_write  = 1'b1;
            dec.jump       = 1'b1;
            dec.result_src = RES_PC4;
            dec.imm_src    = IMM_J;
            legal          = 1'b1;
         end
         OP_JALR: begin
            dec.reg_write  = 1'b1;
            dec.jump       = 1'b1;
            dec.result_src = RES_PC4;
            dec.imm_src    = IMM_I;
            dec.alu_src    = 1'b1;
            dec.sum_src    = 1'b1;
            legal          = (funct3 == 3'b000);
         end
         default: legal = 1'b0;
      endcase
      ctrl_o = legal ? dec : ILLEGAL_BUNDLE;
   end

endmodule

// File: rtl/decode_pipe_ctrl.sv
// Registered decode stage: 2-slot skid buffer of decoded bundles with flush
// and a saturating illegal-instruction counter. Honours DECODE_M_EXT_EN.
module decode_pipe_ctrl
   import decode_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int ILL_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [31:0]          instr_i,
   input  logic [XLEN-1:0]      pc_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [XLEN-1:0]      pc_o,
   output logic                 reg_write_o,
   output logic                 mem_write_o,
   output logic                 jump_o,
   output logic                 branch_o,
   output logic                 alu_src_o,
   output logic                 alu_src_a_o,
   output logic                 sum_src_o,
   output logic [1:0]           result_src_o,
   output logic [2:0]           imm_src_o,
   output logic [4:0]           alu_ctrl_o,
   output logic [1:0]           store_src_o,
   output logic [2:0]           load_src_o,
   output logic [2:0]           branch_type_o,
   output logic                 illegal_o,
   output logic [ILL_CNT_W-1:0] ill_cnt_o,
   output logic                 ill_sticky_o
);

   ctrl_bundle_t         dec_bundle;
   logic                 accept, deq, load_out;

   logic                 out_valid_q, out_valid_d;
   ctrl_bundle_t         out_bundle_q, out_bundle_d;
   logic [XLEN-1:0]      out_pc_q, out_pc_d;
   logic                 skid_valid_q, skid_valid_d;
   ctrl_bundle_t         skid_bundle_q, skid_bundle_d;
   logic [XLEN-1:0]      skid_pc_q, skid_pc_d;
   logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;
   logic                 sticky_q, sticky_d;

   instr_decode_comb u_dec (
      .instr_i (instr_i),
      .ctrl_o  (dec_bundle)
   );

   assign accept   = in_valid_i && !skid_valid_q;
   assign deq      = out_valid_q && out_ready_i;
   assign load_out = !out_valid_q || deq;

   always_comb begin
      out_valid_d   = out_valid_q;
      out_bundle_d  = out_bundle_q;
      out_pc_d      = out_pc_q;
      skid_valid_d  = skid_valid_q;
      skid_bundle_d = skid_bundle_q;
      skid_pc_d     = skid_pc_q;
      ill_cnt_d     = ill_cnt_q;
      sticky_d      = sticky_q;

      if (flush_i) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (load_out) begin
         if (skid_valid_q) begin
            // Older skid entry advances; a same-cycle accept lands behind it.
            out_valid_d  = 1'b1;
            out_bundle_d = skid_bundle_q;
            out_pc_d     = skid_pc_q;
            skid_valid_d = accept;
            if (accept) begin
               skid_bundle_d = dec_bundle;
               skid_pc_d     = pc_i;
            end
         end else begin
            out_valid_d = accept;
            if (accept) begin
               out_bundle_d = dec_bundle;
               out_pc_d     = pc_i;
            end
         end
      end else if (accept) begin
         skid_valid_d  = 1'b1;
         skid_bundle_d = dec_bundle;
         skid_pc_d     = pc_i;
      end

      if (deq && !flush_i && out_bundle_q.illegal) begin
         sticky_d = 1'b1;
         if (ill_cnt_q != {ILL_CNT_W{1'b1}}) begin
            ill_cnt_d = ill_cnt_q + ILL_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q   <= 1'b0;
         out_bundle_q  <= '0;
         out_pc_q      <= '0;
         skid_valid_q  <= 1'b0;
         skid_bundle_q <= '0;
         skid_pc_q     <= '0;
         ill_cnt_q     <= '0;
         sticky_q      <= 1'b0;
      end else begin
         out_valid_q   <= out_valid_d;
         out_bundle_q  <= out_bundle_d;
         out_pc_q      <= out_pc_d;
         skid_valid_q  <= skid_valid_d;
         skid_bundle_q <= skid_bundle_d;
         skid_pc_q     <= skid_pc_d;
         ill_cnt_q     <= ill_cnt_d;
         sticky_q      <= sticky_d;
      end
   end

   assign in_ready_o    = !skid_valid_q;
   assign out_valid_o   = out_valid_q;
   assign pc_o          = out_pc_q;
   assign reg_write_o   = out_bundle_q.reg_write;
   assign mem_write_o   = out_bundle_q.mem_write;
   assign jump_o        = out_bundle_q.jump;
   assign branch_o      = out_bundle_q.branch;
   assign alu_src_o     = out_bundle_q.alu_src;
   assign alu_src_a_o   = out_bundle_q.alu_src_a;
   assign sum_src_o     = out_bundle_q.sum_src;
   assign result_src_o  = out_bundle_q.result_src;
   assign imm_src_o     = out_bundle_q.imm_src;
   assign alu_ctrl_o    = out_bundle_q.alu_ctrl;
   assign store_src_o   = out_bundle_q.store_src;
   assign load_src_o    = out_bundle_q.load_src;
   assign branch_type_o = out_bundle_q.branch_type;
   assign illegal_o     = out_bundle_q.illegal;
   assign ill_cnt_o     = ill_cnt_q;
   assign ill_sticky_o  = sticky_q;

endmodule

// File: tb/tb_decode_pipe_ctrl.sv
// Self-checking bench for decode_pipe_ctrl: queue-based reference model with a
// per-cycle compare, plus directed literal checks.
module tb_decode_pipe_ctrl;

   localparam int XLEN = 32;
   localparam int CW   = 2;

   logic            clk, rst_n, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
   logic [31:0]     instr_i;
   logic [XLEN-1:0] pc_i, pc_o;
   logic reg_write_o, mem_write_o, jump_o, branch_o, alu_src_o, alu_src_a_o, sum_src_o;
   logic [1:0]      result_src_o, store_src_o;
   logic [2:0]      imm_src_o, load_src_o, branch_type_o;
   logic [4:0]      alu_ctrl_o;
   logic            illegal_o, ill_sticky_o;
   logic [CW-1:0]   ill_cnt_o;

   decode_pipe_ctrl #(.XLEN(XLEN), .ILL_CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .instr_i(instr_i), .pc_i(pc_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .pc_o(pc_o),
      .reg_write_o(reg_write_o), .mem_write_o(mem_write_o), .jump_o(jump_o),
      .branch_o(branch_o), .alu_src_o(alu_src_o), .alu_src_a_o(alu_src_a_o),
      .sum_src_o(sum_src_o), .result_src_o(result_src_o), .imm_src_o(imm_src_o),
      .alu_ctrl_o(alu_ctrl_o), .store_src_o(store_src_o), .load_src_o(load_src_o),
      .branch_type_o(branch_type_o), .illegal_o(illegal_o),
      .ill_cnt_o(ill_cnt_o), .ill_sticky_o(ill_sticky_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // {rw,mw,jump,branch,alu_src,alu_src_a,sum_src,result_src,imm_src,alu_ctrl,store_src,load_src,branch_type,illegal}
   logic [25:0] dut_ctrl;
   assign dut_ctrl = {reg_write_o, mem_write_o, jump_o, branch_o, alu_src_o, alu_src_a_o,
                      sum_src_o, result_src_o, imm_src_o, alu_ctrl_o, store_src_o,
                      load_src_o, branch_type_o, illegal_o};

   // ALU code for funct3 0..7 of the plain (non-alternate) R/I operations.
   localparam logic [4:0] F3_ALU [8] = '{5'b00000, 5'b00110, 5'b00101, 5'b01001,
                                         5'b01000, 5'b00111, 5'b00011, 5'b00010};

   function automatic logic [25:0] model_dec(input logic [31:0] ins);
      logic [6:0] op = ins[6:0];
      logic [6:0] f7 = ins[31:25];
      logic [2:0] f3 = ins[14:12];
      logic rw = 0, mw = 0, j = 0, b = 0, as = 0, aa = 0, ss = 0, ok = 0;
      logic [1:0] rs = 0, st = 0;
      logic [2:0] im = 0, ld = 0, bt = 0;
      logic [4:0] alu = 0;
      case (op)
         7'h33: begin
            rw = 1;
            if (f7 == 7'h00) begin ok = 1; alu = F3_ALU[f3]; end
            else if (f7 == 7'h20 && f3 == 3'd0) begin ok = 1; alu = 5'b00001; end
            else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1; alu = 5'b01010; end
`ifdef DECODE_M_EXT_EN
            else if (f7 == 7'h01) begin ok = 1; alu = {2'b10, f3}; end
`endif
         end
         7'h13: begin
            rw = 1; as = 1; im = 3'd1;
            alu = (f3 == 3'd5 && f7 == 7'h20) ? 5'b01010 : F3_ALU[f3];
            ok = (f3 == 3'd1) ? (f7 == 7'h00) :
                 (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
         end
         7'h03: begin rw = 1; as = 1; im = 3'd1; rs = 2'd1; ld = f3;
                      ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}); end
         7'h23: begin mw = 1; as = 1; im = 3'd2;
                      st = (f3 == 3'd2) ? 2'd0 : (f3 == 3'd1) ? 2'd1 : 2'd2; ok = (f3 < 3'd3); end
         7'h63: begin b = 1; im = 3'd3; bt = f3;
                      alu = (f3 < 3'd2) ? 5'b00001 : (f3 < 3'd6) ? 5'b00101 : 5'b01001;
                      ok = !(f3 == 3'd2 || f3 == 3'd3); end
         7'h37: begin rw = 1; as = 1; im = 3'd4; alu = 5'b01011; ok = 1; end
         7'h17: begin rw = 1; as = 1; aa = 1; im = 3'd4; alu = 5'b01100; ok = 1; end
         7'h6F: begin rw = 1; j = 1; rs = 2'd2; im = 3'd5; ok = 1; end
         7'h67: begin rw = 1; j = 1; rs = 2'd2; im = 3'd1; as = 1; ss = 1; ok = (f3 == 3'd0); end
         default: ok = 0;
      endcase
      if (!ok) return 26'd1;
      return {rw, mw, j, b, as, aa, ss, rs, im, alu, st, ld, bt, 1'b0};
   endfunction

   function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
      return {f7, 5'd3, 5'd2, f3, 5'd1, op};
   endfunction

   typedef struct { logic [31:0] instr; logic [31:0] pc; } entry_t;
   entry_t mq[$];
   int     m_cnt = 0;
   logic   m_sticky = 0;

   // Reference model: a 2-deep FIFO of raw instructions, updated at each edge.
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         mq.delete(); m_cnt = 0; m_sticky = 0;
      end else begin
         logic acc, dq;
         acc = in_valid_i && (mq.size() < 2);
         dq  = (mq.size() > 0) && out_ready_i;
         if (flush_i) mq.delete();
         else begin
            if (dq) begin
               if (model_dec(mq[0].instr) == 26'd1) begin
                  m_sticky = 1;
                  if (m_cnt < (1 << CW) - 1) m_cnt++;
               end
               void'(mq.pop_front());
            end
            if (acc) mq.push_back('{instr: instr_i, pc: pc_i});
         end
      end
   end

   initial forever begin
      @(negedge clk);
      chk("in_ready", {31'd0, in_ready_o}, {31'd0, mq.size() < 2});
      chk("out_valid", {31'd0, out_valid_o}, {31'd0, mq.size() > 0});
      chk("ill_cnt", 32'(ill_cnt_o), 32'(m_cnt));
      chk("ill_sticky", {31'd0, ill_sticky_o}, {31'd0, m_sticky});
      if (mq.size() > 0) begin
         chk("pc_o", pc_o, mq[0].pc);
         chk("ctrl", {6'd0, dut_ctrl}, {6'd0, model_dec(mq[0].instr)});
      end
   end

   task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic rdy, input logic fl);
      in_valid_i = v; instr_i = ins; pc_i = pc; out_ready_i = rdy; flush_i = fl;
      @(negedge clk);
   endtask

   localparam logic [31:0] ADD_I = 32'h003100B3;
   localparam logic [31:0] ILL_I = 32'h0000007F;
   localparam logic [31:0] MUL_I = 32'h023100B3;
   logic [31:0] tbl[$];
   int exp_cnt [5] = '{1, 2, 3, 3, 3};

   initial begin
      rst_n = 0; flush_i = 0; in_valid_i = 0; instr_i = 0; pc_i = 0; out_ready_i = 0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
      chk("rst_ctrl", {6'd0, dut_ctrl}, 32'd0);
      rst_n = 1;

      // add x1,x2,x3 into an empty stage
      cyc(1, ADD_I, 32'h100, 1, 0);
      chk("add_valid", {31'd0, out_valid_o}, 32'd1);
      chk("add_rw", {31'd0, reg_write_o}, 32'd1);
      chk("add_alu", {27'd0, alu_ctrl_o}, 32'd0);
      chk("add_imm", {29'd0, imm_src_o}, 32'd0);
      chk("add_ill", {31'd0, illegal_o}, 32'd0);
      chk("add_pc", pc_o, 32'h100);
      cyc(0, 0, 0, 1, 0);

      // backpressure: A then B, then drain
      cyc(1, 32'h00500093, 32'h200, 0, 0);
      cyc(1, 32'h0000A103, 32'h204, 0, 0);
      chk("bp_in_ready", {31'd0, in_ready_o}, 32'd0);
      chk("bp_pc_a", pc_o, 32'h200);
      cyc(0, 0, 0, 1, 0);
      chk("bp_pc_b", pc_o, 32'h204);
      chk("bp_ready_back", {31'd0, in_ready_o}, 32'd1);
      cyc(0, 0, 0, 1, 0);
      chk("bp_empty", {31'd0, out_valid_o}, 32'd0);

      // flush with both slots full (illegal in front must not count)
      cyc(1, ILL_I, 32'h300, 0, 0);
      cyc(1, ADD_I, 32'h304, 0, 0);
      cyc(1, ADD_I, 32'h308, 1, 1);
      chk("fl_valid", {31'd0, out_valid_o}, 32'd0);
      chk("fl_ready", {31'd0, in_ready_o}, 32'd1);
      chk("fl_cnt", 32'(ill_cnt_o), 32'd0);
      // flush drops an input accepted in the same cycle
      cyc(1, ADD_I, 32'h30C, 0, 0);
      cyc(1, ADD_I, 32'h310, 0, 1);
      chk("fl_drop", {31'd0, out_valid_o}, 32'd0);
      cyc(0, 0, 0, 1, 0);

      // illegal saturation with a 2-bit counter
      cyc(1, ILL_I, 32'h340, 0, 0);
      chk("ill_flag", {31'd0, illegal_o}, 32'd1);
      chk("ill_rw", {31'd0, reg_write_o}, 32'd0);
      chk("ill_mw", {31'd0, mem_write_o}, 32'd0);
      for (int k = 1; k <= 5; k++) begin
         cyc(k < 5, ILL_I, 32'h340 + 32'(4 * k), 1, 0);
         chk("ill_cnt_seq", 32'(ill_cnt_o), 32'(exp_cnt[k-1]));
         chk("ill_sticky_set", {31'd0, ill_sticky_o}, 32'd1);
      end

      // mul x1,x2,x3
      cyc(1, MUL_I, 32'h400, 0, 0);
`ifdef DECODE_M_EXT_EN
      chk("mul_alu", {27'd0, alu_ctrl_o}, 32'h10);
      chk("mul_ill", {31'd0, illegal_o}, 32'd0);
`else
      chk("mul_ill", {31'd0, illegal_o}, 32'd1);
`endif
      cyc(0, 0, 0, 1, 0);

      // directed table over every opcode class and funct3/funct7 combination
      for (int f = 0; f < 8; f++) begin
         tbl.push_back(mk(7'h00, 3'(f), 7'h33));
         tbl.push_back(mk(7'h00, 3'(f), 7'h13));
         tbl.push_back(mk(7'h11, 3'(f), 7'h03));
         tbl.push_back(mk(7'h11, 3'(f), 7'h23));
         tbl.push_back(mk(7'h22, 3'(f), 7'h63));
         tbl.push_back(mk(7'h20, 3'(f), 7'h33));
         tbl.push_back(mk(7'h01, 3'(f), 7'h33));
         tbl.push_back(mk(7'h20, 3'(f), 7'h13));
         tbl.push_back(mk(7'h5A, 3'(f), 7'h67));
      end
      tbl.push_back(mk(7'h10, 3'd5, 7'h13));
      tbl.push_back(mk(7'h55, 3'd0, 7'h13));
      tbl.push_back(mk(7'h7F, 3'd0, 7'h33));
      tbl.push_back(mk(7'h12, 3'd3, 7'h37));
      tbl.push_back(mk(7'h12, 3'd6, 7'h17));
      tbl.push_back(mk(7'h12, 3'd1, 7'h6F));
      tbl.push_back(32'h0000000F);
      tbl.push_back(32'h00000000);
      begin
         int i = 0, c = 0;
         while (i < tbl.size() && c < 500) begin
            logic acc;
            acc = (mq.size() < 2);
            cyc(1, tbl[i], 32'h1000 + 32'(4 * i), (c % 3) != 2, 0);
            if (acc) i++;
            c++;
         end
         chk("tbl_done", 32'(i), 32'(tbl.size()));
      end
      repeat (3) cyc(0, 0, 0, 1, 0);

      // asynchronous reset with both slots full
      cyc(1, ADD_I, 32'h500, 0, 0);
      cyc(1, ADD_I, 32'h504, 0, 0);
      #2 rst_n = 0;
      #1;
      chk("arst_valid", {31'd0, out_valid_o}, 32'd0);
      chk("arst_ready", {31'd0, in_ready_o}, 32'd1);
      chk("arst_cnt", 32'(ill_cnt_o), 32'd0);
      chk("arst_sticky", {31'd0, ill_sticky_o}, 32'd0);
      chk("arst_pc", pc_o, 32'd0);
      chk("arst_ctrl", {6'd0, dut_ctrl}, 32'd0);
      in_valid_i = 0;
      @(negedge clk);
      rst_n = 1;
      repeat (2) cyc(0, 0, 0, 1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_pipe_ctrl.md
Name: decode_pipe_ctrl

Overview:
- Registered, handshaked RV32I decode stage that sits between the F/D pipeline register and the execute stage.
- Turns each 32-bit instruction into a control bundle and buffers it in a 2-slot skid buffer (output slot plus skid slot).
- Replaces X-propagating defaults with a defined illegal-instruction bundle, and keeps a saturating illegal-instruction counter.
- Carries the PC through alongside each decoded instruction.

Parameters:
- XLEN, 32: width of pc_i/pc_o.
- ILL_CNT_W, 8: width of the illegal-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous pipeline flush.
- in_valid_i  in  1  instruction valid.
- in_ready_o  out  1  stage can accept.
- instr_i  in  32  instruction word.
- pc_i  in  XLEN  instruction PC.
- out_valid_o  out  1  bundle valid.
- out_ready_i  in  1  execute stage accepts.
- pc_o  out  XLEN  PC of the bundle.
- reg_write_o, mem_write_o, jump_o, branch_o, alu_src_o, alu_src_a_o, sum_src_o  out  1 each  control bits.
- result_src_o  out  2  00 ALU, 01 memory, 10 PC+4.
- imm_src_o  out  3  R000 I001 S010 B011 U100 J101.
- alu_ctrl_o  out  5  ALU operation.
- store_src_o  out  2  SW00 SH01 SB10.
- load_src_o  out  3  load funct3 passthrough.
- branch_type_o  out  3  branch funct3 passthrough.
- illegal_o  out  1  bundle is an illegal instruction.
- ill_cnt_o  out  ILL_CNT_W  saturating illegal count.
- ill_sticky_o  out  1  set on the first illegal dequeue.

Behaviour:
- Reset: every output is 0, except in_ready_o=1. Both slots are empty.
- Handshakes:
  - Accept when in_valid_i && in_ready_o. Dequeue when out_valid_o && out_ready_i.
  - in_ready_o = !skid_valid, taken from a register (no combinational path from out_ready_i).
  - Latency: an accept into an empty stage gives out_valid_o=1 on the next edge.
- Slot rules:
  - The output slot loads the new instruction if it is empty or being dequeued; otherwise the instruction goes to the skid slot.
  - On dequeue with skid_valid, the skid entry moves to the output slot. If an accept happens in the same cycle, the new entry goes to the skid slot.
  - Order is strictly FIFO.
  - Outputs are stable while out_valid_o && !out_ready_i.
- Flush has priority over everything:
  - Next edge: both slots are empty.
  - An input accepted in the flush cycle is dropped.
  - No counter update occurs for a bundle dequeued in the flush cycle.
- Decode:
  - Alu codes: ADD00000 SUB00001 AND00010 OR00011 SLT00101 SLL00110 SRL00111 XOR01000 SLTU01001 SRA01010 PASSB01011 PCADD01100.
  - R-type 0110011: funct7 0000000 gives all eight ops; 0100000 gives SUB and SRA only.
  - I-ALU 0010011: funct3 101 needs funct7 0000000 (SRLI) or 0100000 (SRAI). funct3 001 needs funct7 0000000.
  - Loads: funct3 011/110/111 are illegal.
  - Stores: funct3 ≥011 is illegal.
  - Branches: funct3 010/011 are illegal. BEQ/BNE use SUB, BLT/BGE use SLT, BLTU/BGEU use SLTU.
  - LUI uses PASSB. AUIPC uses PCADD with alu_src_a=1.
  - JAL/JALR: jump=1, result_src=10. JALR sets sum_src=1; JALR with funct3≠000 is illegal.
- Illegal instructions (any other opcode, or an illegal field combination):
  - Bundle is all zeros with illegal_o=1. It is never X.
  - reg_write, mem_write, branch and jump are guaranteed 0.
- Counter:
  - Increments on dequeue of a bundle with illegal=1, and saturates at 2^ILL_CNT_W−1.
  - ill_sticky_o is set on the same event and cleared only by reset.
  - Flush does not clear the counter or the sticky bit.
- Reset asserted mid-transfer: both slots are emptied immediately (asynchronously) and the counter is cleared.

Optional Feature:
- Macro: DECODE_M_EXT_EN.
- Defined: opcode 0110011 with funct7 0000001 decodes to alu_ctrl {2'b10, funct3}, with reg_write=1 and illegal=0.
- Undefined: that encoding is illegal.

Decomposition:
- Package decode_pkg holds:
  - opcode localparams;
  - alu_ctrl_e, imm_src_e, result_src_e enums;
  - ctrl_bundle_t packed struct (all control fields plus illegal);
  - ILLEGAL_BUNDLE constant.
- Sub-module instr_decode_comb: purely combinational, instr → ctrl_bundle_t; the M-extension decode sits here.
- Top level: skid buffer, flush logic, counter.

Test Plan:
- add x1,x2,x3 (0x003100B3), empty stage, out_ready=1 → next cycle out_valid=1, reg_write=1, alu_ctrl=00000, imm_src=000, illegal=0.
- out_ready=0 with instrs A and B accepted → in_ready=0 after B. Raise out_ready → A then B on consecutive cycles, pc_o matching, and in_ready returns to 1.
- 0x0000007F with ILL_CNT_W=2, dequeued five times → illegal=1, reg_write=mem_write=0, ill_cnt 1,2,3,3,3, ill_sticky=1.
- Both slots full, flush_i=1 with in_valid=1 → next cycle out_valid=0, in_ready=1, ill_cnt unchanged.
- mul x1,x2,x3 (0x023100B3) → with DECODE_M_EXT_EN alu_ctrl=10000, illegal=0; without it illegal=1.
- rst_n pulsed low between edges with both slots full → outputs zero immediately, in_ready=1.
